// File: rtl/cpu_out_uart.sv
// Captures CPU output-register writes into a small FIFO and serialises them as UART frames on tx.
// Optional macro PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module cpu_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_LOG2    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       loadQ,
    input  logic [7:0] qbus,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       dropped
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_LOG2:0] DEPTH_CNT = (FIFO_LOG2 + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [7:0]           fifoMem [DEPTH];
    logic [FIFO_LOG2-1:0] wrPtr;
    logic [FIFO_LOG2-1:0] rdPtr;
    logic [FIFO_LOG2:0]   count;
    state_t               state;
    state_t               stateNext;
    logic [CNT_W-1:0]     baudCnt;
    logic [2:0]           bitIdx;
    logic [7:0]           shiftReg;
    logic                 txNext;
    logic                 fifoFull;
    logic                 doWrite;
    logic                 doPop;
    logic                 bitEnd;

`ifdef PARITY_EN
    logic parityBit;

    function automatic logic evenParity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    assign fifoFull = (count == DEPTH_CNT);
    assign doWrite  = loadQ && !fifoFull;
    assign doPop    = (state == IDLE) && (count != '0);
    assign bitEnd   = (baudCnt == LAST_CNT);

    // FIFO storage is pure data and is left unreset; only pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            fifoMem[wrPtr] <= qbus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            dropped <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (loadQ && fifoFull) begin
                dropped <= 1'b1;
            end
            case ({doWrite, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (count != '0) stateNext = START;
            START: if (bitEnd) stateNext = DATA;
            DATA: begin
                if (bitEnd && bitIdx == 3'd7) begin
`ifdef PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef PARITY_EN
            PARITY: if (bitEnd) stateNext = STOP;
`endif
            STOP:  if (bitEnd) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // tx is registered, so it is computed from the state being entered on this edge.
    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START:  txNext = 1'b0;
            DATA:   txNext = (state == DATA && bitEnd) ? shiftReg[1] : shiftReg[0];
`ifdef PARITY_EN
            PARITY: txNext = parityBit;
`endif
            default: txNext = 1'b1;
        endcase
        busy = (state != IDLE) || (count != '0);
        full = fifoFull;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx      <= 1'b1;
            baudCnt <= '0;
            bitIdx  <= '0;
        end else begin
            tx <= txNext;
            if (state == IDLE) begin
                baudCnt <= '0;
                bitIdx  <= '0;
            end else begin
                baudCnt <= bitEnd ? '0 : baudCnt + 1'b1;
                if (state == DATA && bitEnd) begin
                    bitIdx <= bitIdx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPop) begin
            shiftReg <= fifoMem[rdPtr];
        end else if (state == DATA && bitEnd) begin
            shiftReg <= shiftReg >> 1;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk) begin
        if (doPop) begin
            parityBit <= evenParity(fifoMem[rdPtr]);
        end
    end
`endif

endmodule

// File: doc/cpu_out_uart.md
Name: cpu_out_uart

Overview:
Downstream consumer of the CPU's output register. Every cycle the CPU loads its output register, this block captures the same byte into a small FIFO and serialises it as an 8N1 UART frame on `tx`. The bench and board use it to observe program output as a serial stream. It decouples CPU write bursts from the slow serial line.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥2.
FIFO_LOG2, 2, log2 of FIFO depth (default depth 4).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
loadQ  input  1  write strobe; high for one cycle when the CPU loads its output register.
qbus  input  8  byte being written (data bus value in the loadQ cycle).
tx  output  1  serial line, idle high; registered.
full  output  1  FIFO holds 2^FIFO_LOG2 entries.
busy  output  1  high when the FIFO is non-empty or a frame is in progress.
dropped  output  1  sticky overflow flag.

Behaviour:
- Reset: clocked on an edge with reset=1.
  - tx=1, full=0, busy=0, dropped=0.
  - FIFO emptied (pointers and count = 0).
  - FSM=IDLE, bit and baud counters = 0.
  - Reset mid-frame aborts the frame immediately; tx=1 after that edge.
- FIFO write:
  - A write happens on an edge with loadQ=1 and the pre-edge count < depth; it stores qbus at the tail.
  - If the pre-edge count equals depth, the byte is discarded and dropped←1. dropped stays set until reset, even if a pop happens on the same edge.
  - Write and pop on the same edge with a non-full FIFO: both happen and the count is unchanged.
  - Pointers wrap modulo depth.
  - full and busy are derived from the registered count and FSM state, so they are valid the cycle after the edge that changes them.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the pre-edge count > 0, pop the head into an 8-bit shift register, clear the baud counter, go to START. A byte written at edge N is popped at edge N+1, so tx=0 is visible after edge N+1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Each frame is 10×CLKS_PER_BIT cycles, plus at least 1 IDLE cycle between back-to-back frames.
- Baud counter: counts 0..CLKS_PER_BIT−1 and wraps. A bit period ends on the edge where the counter equals CLKS_PER_BIT−1.
- busy = (state≠IDLE) or (count≠0).
- loadQ while qbus is X is never written if the FIFO is full.

Optional Feature:
PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame length becomes 11×CLKS_PER_BIT.
- Undefined: no PARITY state; plain 8N1 framing as above.

Test Plan:
1. CLKS_PER_BIT=4, reset, then one loadQ with qbus=0x41. Required: tx goes low the cycle after the pop, then shows 0,1,0,0,0,0,0,1,0,1, each held 4 cycles; busy falls 1 cycle after the stop bit ends.
2. Five consecutive loadQ cycles (0x01..0x05) with depth 4. Required: the first is popped to the shifter; 0x02..0x05 fill the FIFO; no drop; all five frames are emitted in order with 1 idle cycle between frames.
3. FIFO full and frame in progress, then loadQ with 0xAA. Required: dropped=1 and stays 1; 0xAA never appears on tx.
4. Reset asserted during DATA bit 3 of 0xFF. Required: tx=1, busy=0, full=0, dropped=0 after that edge; a new write of 0x00 then transmits a clean frame.
5. loadQ on the same edge as the IDLE pop with count=1. Required: the count stays 1, and the second byte follows immediately after the first frame.
6. PARITY_EN with 0x07 (three ones). Required: parity bit=1 after bit 7, then the stop bit; frame is 44 cycles at CLKS_PER_BIT=4.
